// File: rtl/apb_pkg.sv
// apb_pkg: state encoding and default address-map constants shared by the
// apb_manager_n bridge and its address decoder.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DERR
  } apb_state_e;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
  localparam int unsigned DEF_SUB_SHIFT = 12;

endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: maps a request address onto one of NUM_SUB equal windows
// starting at BASE_ADDR; purely combinational.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int unsigned       NUM_SUB   = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter int unsigned       SUB_SHIFT = DEF_SUB_SHIFT
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic               hit,
  output logic [NUM_SUB-1:0] sel
);

  // One extra bit so a region ending exactly at the top of the address space
  // cannot wrap to zero.
  localparam logic [ADDR_W:0] REGION_SIZE = (ADDR_W + 1)'(NUM_SUB) << SUB_SHIFT;

  logic [ADDR_W-1:0] offset;

  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    offset = addr - BASE_ADDR;
    hit    = (addr >= BASE_ADDR) && ({1'b0, offset} < REGION_SIZE);
    sel    = hit ? (NUM_SUB'(1) << (offset >> SUB_SHIFT)) : '0;
  end

endmodule

// File: rtl/apb_manager_n.sv
// apb_manager_n: bridges a single-outstanding processor request port onto an
// APB bus with NUM_SUB subordinates. Define APB_TIMEOUT_EN to abort stalled accesses.
module apb_manager_n
  import apb_pkg::*;
#(
  parameter int unsigned       NUM_SUB     = 4,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
  parameter int unsigned       SUB_SHIFT   = DEF_SUB_SHIFT,
  parameter int unsigned       TIMEOUT_CYC = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [NUM_SUB-1:0]        PSEL,
  input  logic [NUM_SUB*DATA_W-1:0] PRDATA,
  input  logic [NUM_SUB-1:0]        PREADY,
  input  logic [NUM_SUB-1:0]        PSLVERR,
  input  logic                      transfer,
  input  logic                      write,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ready,
  output logic                      error,
  output logic                      busy
);

  apb_state_e         state;
  logic               dec_hit;
  logic [NUM_SUB-1:0] dec_sel;
  logic               sub_ready;
  logic               sub_err;
  logic [DATA_W-1:0]  sub_rdata;

  apb_addr_decoder #(
    .NUM_SUB   (NUM_SUB),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .SUB_SHIFT (SUB_SHIFT)
  ) u_decoder (
    .addr (addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  // PSEL is the registered one-hot select, so it masks off every other subordinate.
  always_comb begin
    sub_ready = |(PREADY & PSEL);
    sub_err   = |(PSLVERR & PSEL);
    sub_rdata = '0;
    for (int i = 0; i < NUM_SUB; i++) begin
      if (PSEL[i]) sub_rdata = sub_rdata | PRDATA[i*DATA_W +: DATA_W];
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(TIMEOUT_CYC + 1) > 5) ? $clog2(TIMEOUT_CYC + 1) : 5;
  logic [TO_W-1:0] to_cnt;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state   <= IDLE;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      error   <= 1'b0;
      busy    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      ready <= 1'b0;
      error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (transfer) begin
            busy   <= 1'b1;
            PWRITE <= write;
            PADDR  <= addr;
            PWDATA <= wdata;
            if (dec_hit) begin
              PSEL  <= dec_sel;
              state <= SETUP;
`ifdef APB_TIMEOUT_EN
              to_cnt <= '0;
`endif
            end else begin
              state <= DERR;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (sub_ready) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            ready   <= 1'b1;
            error   <= sub_err;
            rdata   <= PWRITE ? '0 : sub_rdata;
            busy    <= 1'b0;
            state   <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            ready   <= 1'b1;
            error   <= 1'b1;
            rdata   <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        DERR: begin
          ready <= 1'b1;
          error <= 1'b1;
          rdata <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_manager_n.sv
// tb_apb_manager_n: directed vector table plus randomized requests against
// behavioural APB subordinates and an address-map reference model.
module tb_apb_manager_n;

  localparam int NS = 4;
  localparam int TO = 16;
  localparam longint unsigned BASE = 64'h1000_0000;
  localparam longint unsigned WIN  = 64'd4096;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              PCLK;
  logic              PRESET;
  logic [31:0]       PADDR;
  logic              PWRITE;
  logic              PENABLE;
  logic [31:0]       PWDATA;
  logic [NS-1:0]     PSEL;
  logic [NS*32-1:0]  PRDATA;
  logic [NS-1:0]     PREADY;
  logic [NS-1:0]     PSLVERR;
  logic              transfer;
  logic              write;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              error;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  int sub_wait = 0;
  bit sub_err  = 1'b0;
  int wcnt [NS];
  logic [31:0] sub_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  typedef struct {
    string       name;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          wt;
    bit          se;
    bit          hit;
    logic [NS-1:0] sel;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [13];

  apb_manager_n dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PENABLE  (PENABLE),
    .PWDATA   (PWDATA),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .error    (error),
    .busy     (busy)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Subordinates: the selected one inserts sub_wait wait states during ACCESS;
  // all idle subordinates drive random PREADY/PSLVERR/PRDATA.
  always @(negedge PCLK) begin
    for (int i = 0; i < NS; i++) begin
      if (PSEL[i] && PENABLE) begin
        if (wcnt[i] < sub_wait) begin
          PREADY[i]  = 1'b0;
          PSLVERR[i] = 1'($urandom);
          PRDATA[i*32 +: 32] = $urandom;
          wcnt[i]++;
        end else begin
          PREADY[i]  = 1'b1;
          PSLVERR[i] = sub_err;
          if (PWRITE) begin
            sub_mem[PADDR] = PWDATA;
            PRDATA[i*32 +: 32] = $urandom;
          end else begin
            PRDATA[i*32 +: 32] = sub_mem.exists(PADDR) ? sub_mem[PADDR] : 32'h0;
          end
        end
      end else begin
        wcnt[i]    = 0;
        PREADY[i]  = 1'($urandom);
        PSLVERR[i] = 1'($urandom);
        PRDATA[i*32 +: 32] = $urandom;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Address map and data behaviour written from the map rules, not the FSM.
  function automatic void ref_model(input bit wr, input logic [31:0] a, input bit se,
                                    output bit hit, output logic [NS-1:0] sel,
                                    output bit err, output logic [31:0] rd);
    longint unsigned au;
    au  = {32'h0, a};
    hit = (au >= BASE) && (au < BASE + NS * WIN);
    sel = '0;
    if (hit) sel[(au - BASE) / WIN] = 1'b1;
    err = !hit || se;
    rd  = (hit && !wr && ref_mem.exists(a)) ? ref_mem[a] : 32'h0;
  endfunction

  // Issues one request at the current falling edge and checks every cycle up
  // to and including the ready pulse; leaves the bench on that falling edge.
  task automatic run_txn(input string name, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input int wt, input bit se,
                         input bit hit, input logic [NS-1:0] sel, input bit err,
                         input logic [31:0] rd);
    int  k_done;
    bit  timed_out;
    timed_out = hit && TO_EN && (wt >= TO);
    k_done    = !hit ? 2 : (timed_out ? 2 + TO : 3 + wt);
    sub_wait  = wt;
    sub_err   = se;
    transfer  = 1'b1;
    write     = wr;
    addr      = a;
    wdata     = wd;
    for (int k = 1; k <= k_done; k++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      if (k < k_done) begin
        if (hit)
          check($sformatf("%s/apb_k%0d", name, k),
                {ready, busy, PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                {1'b0, 1'b1, sel, (k >= 2), wr, a, wd});
        else
          check($sformatf("%s/derr_k%0d", name, k),
                {ready, busy, PSEL, PENABLE}, {1'b0, 1'b1, {NS{1'b0}}, 1'b0});
        transfer = 1'($urandom);
        write    = 1'($urandom);
        addr     = $urandom;
        wdata    = $urandom;
      end else begin
        check($sformatf("%s/done", name),
              {ready, error, busy, PSEL, PENABLE}, {1'b1, err, 1'b0, {NS{1'b0}}, 1'b0});
        check($sformatf("%s/rdata", name), rdata, rd);
        transfer = 1'b0;
      end
    end
    if (hit && wr && !timed_out) ref_mem[a] = wd;
  endtask

  initial begin
    bit            r_wr;
    logic [31:0]   r_a;
    logic [31:0]   r_wd;
    int            r_wt;
    bit            r_se;
    bit            r_hit;
    logic [NS-1:0] r_sel;
    bit            r_err;
    logic [31:0]   r_rd;
    int            kind;

    vecs[0]  = '{"wr_s2",        1'b1, 32'h1000_2040, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, 4'b0100, 1'b0, 32'h0};
    vecs[1]  = '{"rd_s2",        1'b0, 32'h1000_2040, 32'h1111_2222, 0, 1'b0, 1'b1, 4'b0100, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{"wr_s1",        1'b1, 32'h1000_1000, 32'h1234_5678, 0, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h0};
    vecs[3]  = '{"rd_s1_wait3",  1'b0, 32'h1000_1000, 32'h0,         3, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h1234_5678};
    vecs[4]  = '{"miss_hi",      1'b0, 32'h2000_0000, 32'h0,         0, 1'b0, 1'b0, 4'b0000, 1'b1, 32'h0};
    vecs[5]  = '{"miss_end",     1'b1, 32'h1000_4000, 32'hCAFE_F00D, 0, 1'b0, 1'b0, 4'b0000, 1'b1, 32'h0};
    vecs[6]  = '{"wr_s3_wait1",  1'b1, 32'h1000_3FFC, 32'hA5A5_0F0F, 1, 1'b0, 1'b1, 4'b1000, 1'b0, 32'h0};
    vecs[7]  = '{"rd_s3_slverr", 1'b0, 32'h1000_3FFC, 32'h0,         0, 1'b1, 1'b1, 4'b1000, 1'b1, 32'hA5A5_0F0F};
    vecs[8]  = '{"miss_lo",      1'b0, 32'h0FFF_FFFC, 32'h0,         0, 1'b0, 1'b0, 4'b0000, 1'b1, 32'h0};
    vecs[9]  = '{"wr_s0_wait2",  1'b1, 32'h1000_0000, 32'h0000_0001, 2, 1'b0, 1'b1, 4'b0001, 1'b0, 32'h0};
    vecs[10] = '{"rd_s0",        1'b0, 32'h1000_0000, 32'h0,         0, 1'b0, 1'b1, 4'b0001, 1'b0, 32'h0000_0001};
    vecs[11] = '{"miss_top",     1'b0, 32'hFFFF_FFFC, 32'h0,         0, 1'b0, 1'b0, 4'b0000, 1'b1, 32'h0};
    vecs[12] = '{"wr_s1_slverr", 1'b1, 32'h1000_1FFC, 32'h5555_AAAA, 2, 1'b1, 1'b1, 4'b0010, 1'b1, 32'h0};

    PRESET   = 1'b0;
    transfer = 1'b0;
    write    = 1'b0;
    addr     = '0;
    wdata    = '0;
    PREADY   = '0;
    PSLVERR  = '0;
    PRDATA   = '0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check("reset_state", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rdata, ready, error, busy}, '0);
    PRESET = 1'b1;

    for (int v = 0; v < 13; v++)
      run_txn(vecs[v].name, vecs[v].wr, vecs[v].a, vecs[v].wd, vecs[v].wt, vecs[v].se,
              vecs[v].hit, vecs[v].sel, vecs[v].err, vecs[v].rd);

    for (int c = 0; c < 2; c++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      check("idle_quiet", {ready, busy, PSEL, PENABLE}, '0);
    end

    if (TO_EN)
      run_txn("timeout", 1'b0, 32'h1000_3000, 32'h0, 1000, 1'b0, 1'b1, 4'b1000, 1'b1, 32'h0);

    // Reset asserted for one edge while a read is stalled in ACCESS.
    sub_wait = 5;
    sub_err  = 1'b0;
    transfer = 1'b1;
    write    = 1'b0;
    addr     = 32'h1000_1004;
    wdata    = 32'h0;
    @(posedge PCLK);
    @(negedge PCLK);
    transfer = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check("pre_reset_access", {PSEL, PENABLE}, {4'b0010, 1'b1});
    PRESET = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check("mid_reset_zero", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rdata, ready, error, busy}, '0);
    PRESET = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      check("post_reset_no_ready", {ready, busy, PSEL}, '0);
    end
    run_txn("post_reset_wr", 1'b1, 32'h1000_1004, 32'h0BAD_F00D, 1, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h0);
    run_txn("post_reset_rd", 1'b0, 32'h1000_1004, 32'h0, 0, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h0BAD_F00D);

    for (int i = 0; i < 40; i++) begin
      r_wr = 1'($urandom);
      kind = int'($urandom_range(0, 7));
      if (kind < 6)       r_a = 32'h1000_0000 + ($urandom_range(0, 15) << 10);
      else if (kind == 6) r_a = 32'h1000_4000 + ($urandom_range(0, 63) << 2);
      else                r_a = $urandom;
      r_wd = $urandom;
      r_wt = int'($urandom_range(0, 3));
      r_se = ($urandom_range(0, 7) == 0);
      ref_model(r_wr, r_a, r_se, r_hit, r_sel, r_err, r_rd);
      run_txn($sformatf("rand%0d", i), r_wr, r_a, r_wd, r_wt, r_se, r_hit, r_sel, r_err, r_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_manager_n.md
# apb_manager_n

Parametrised APB manager bridging the processor-side request port (`transfer`/`write`/`addr`/`wdata` → `rdata`/`ready`) onto an APB bus with `NUM_SUB` subordinates. Successor to the fixed four-subordinate manager, adding:
- parametrised address decode;
- subordinate wait-state and `PSLVERR` support;
- decode-error reporting;
- an optional access timeout.

Sits between the RISC-V core's memory-mapped I/O path and the peripheral subordinates.

## Interface
- `NUM_SUB`, 4: number of subordinates (1–16).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `BASE_ADDR`, 32'h1000_0000: start of the peripheral region.
- `SUB_SHIFT`, 12: log2 of the window size per subordinate (4 KiB).
- `TIMEOUT_CYC`, 16: number of ACCESS cycles without `PREADY` before abort (used only with `APB_TIMEOUT_EN`).

Ports:
- `PCLK` in 1: clock; all logic on its rising edge.
- `PRESET` in 1: reset, synchronous, active-low.
- `PADDR` out ADDR_W: APB address.
- `PWRITE` out 1: APB direction.
- `PENABLE` out 1: APB enable.
- `PWDATA` out DATA_W: APB write data.
- `PSEL` out NUM_SUB: one-hot subordinate select.
- `PRDATA` in NUM_SUB*DATA_W: flattened read data; subordinate i occupies `[i*DATA_W +: DATA_W]`.
- `PREADY` in NUM_SUB: per-subordinate ready.
- `PSLVERR` in NUM_SUB: per-subordinate error.
- `transfer` in 1: request strobe, sampled only when not `busy`.
- `write` in 1: 1 = write.
- `addr` in ADDR_W: request address.
- `wdata` in DATA_W: request write data.
- `rdata` out DATA_W: read data, valid while `ready` is high.
- `ready` out 1: one-cycle completion pulse.
- `error` out 1: qualifies `ready`; high on decode error, `PSLVERR`, or timeout.
- `busy` out 1: high from request acceptance until the cycle `ready` is asserted.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DERR.
- **IDLE:** on `transfer`=1, register `write`/`addr`/`wdata` and raise `busy`.
  - Decode hit → SETUP.
  - Decode miss → DERR.
- **Decode:**
  - Hit iff `BASE_ADDR <= addr < BASE_ADDR + (NUM_SUB << SUB_SHIFT)`.
  - Index = `(addr - BASE_ADDR) >> SUB_SHIFT`, computed in ADDR_W-bit unsigned arithmetic with no wrap past the top of the region.
- **SETUP:** `PSEL[idx]`=1, `PENABLE`=0, `PADDR`/`PWRITE`/`PWDATA` driven from the registered request. Next state: ACCESS.
- **ACCESS:** `PSEL[idx]`=1, `PENABLE`=1; APB outputs held stable.
  - On `PREADY[idx]`=1: capture `PRDATA` slice (reads only; writes give `rdata`=0), capture `PSLVERR[idx]` into `error`, pulse `ready`, go to IDLE.
  - Otherwise stay in ACCESS (wait state).
- **DERR:** no `PSEL` asserted; next edge pulses `ready`=1, `error`=1, `rdata`=0; go to IDLE.
- `transfer` while `busy` is ignored; no queueing.
- A request may be accepted in the same cycle `ready` is high (back-to-back).
- `PREADY`/`PSLVERR` of non-selected subordinates are ignored.
- **Reset** (`PRESET`=0 at a rising edge), including mid-transaction:
  - FSM → IDLE, timeout counter cleared, no `ready` pulse for the aborted transfer.
  - Output values: `PSEL`=0, `PENABLE`=0, `PWRITE`=0, `PADDR`=0, `PWDATA`=0, `rdata`=0, `ready`=0, `error`=0, `busy`=0.

## Timing
- Request sampled at edge E0, SETUP after E0, ACCESS after E1.
- Zero-wait subordinate: `PREADY` sampled at E2; `ready` high for the cycle after E2. Minimum latency is 3 edges.
- Each wait cycle adds one edge.
- Decode error: `ready`/`error` high for the cycle after E1.
- `PSEL`/`PENABLE` deassert in the same cycle `ready` rises.
- `ready`, `error`, `rdata` are registered; no combinational path from any input to any output.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - 5-bit-or-wider counter (width = `$clog2(TIMEOUT_CYC+1)`) increments for each ACCESS cycle with `PREADY[idx]`=0.
  - On reaching `TIMEOUT_CYC`: drop `PSEL`/`PENABLE`, pulse `ready`=1, `error`=1, `rdata`=0, go to IDLE.
  - Counter clears on entry to SETUP.
- `APB_TIMEOUT_EN` undefined: no counter logic; ACCESS waits indefinitely; `TIMEOUT_CYC` unused.

## Structure
- Package `apb_pkg`: `apb_state_e` enum (IDLE, SETUP, ACCESS, DERR) and default constants for `BASE_ADDR` and `SUB_SHIFT`.
- Sub-module `apb_addr_decoder`: combinational; outputs `hit` and one-hot `sel[NUM_SUB]`. Instantiated once on the request address.

## Test plan
- Write `addr`=0x1000_2040, `wdata`=0xDEAD_BEEF, zero-wait subordinate → `PSEL`=4'b0100 for 2 cycles, `PENABLE` in 2nd, `ready` 3 edges after accept, `error`=0.
- Read back 0x1000_2040 → `rdata`=0xDEAD_BEEF with `ready`, `PWRITE`=0.
- Subordinate 1 holds `PREADY` low for 3 ACCESS cycles, read 0x1000_1000 → `ready` 6 edges after accept, APB outputs stable throughout.
- `addr`=0x2000_0000 and `addr`=0x1000_4000 → `PSEL`=0 always, `ready`=1, `error`=1, `rdata`=0 one cycle after DERR.
- Subordinate 3 returns `PSLVERR`=1 with `PREADY` → `ready`=1, `error`=1. With `APB_TIMEOUT_EN`, `PREADY` never rises → abort after 16 ACCESS cycles with `error`=1.
- `PRESET`=0 for one edge during ACCESS → all outputs zero next cycle, no `ready`; next `transfer` completes normally.
